// File: rtl/sar_search_controller.sv
// ----------------------------------------------------------------------------
// sar_search_controller
//
// Successive-approximation search engine. It drives a trial value into an
// external zero-latency magnitude comparator and resolves the target MSB
// first from the returned gt/eq/lt flags.
//
// Optional feature macro: SAR_EARLY_EXIT_EN
//   defined   : an eq probe ends the search at once (result = trial).
//   undefined : all WIDTH probes always run; eq only sets the sticky found.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request a new search (ignored while a search runs)
//   gt      in   comparator flag: trial >  target
//   eq      in   comparator flag: trial == target
//   lt      in   comparator flag: trial <  target
//   trial   out  [WIDTH] current probe value presented to the comparator
//   busy    out  high while the search runs
//   done    out  one-cycle pulse when the search completes
//   result  out  [WIDTH] resolved value, held until the next accepted start
//   found   out  an eq probe was observed during the last search
//   err     out  last search aborted on an invalid flag code
// ----------------------------------------------------------------------------
module sar_search_controller #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             gt,
    input  logic             eq,
    input  logic             lt,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when exactly one of the three comparator flags is asserted.
    function automatic logic flags_onehot(input logic [2:0] f);
        logic ok;
        case (f)
            3'b100:  ok = 1'b1;
            3'b010:  ok = 1'b1;
            3'b001:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;

    logic             flags_ok_s;
    logic [IDX_W-1:0] idx_m1_s;
    logic [WIDTH-1:0] trial_upd_s;
    logic [WIDTH-1:0] trial_probe_s;

    // Resolve the current bit from the flags and form the next probe.
    // eq keeps the bit exactly like lt; only gt clears it.
    always_comb begin
        flags_ok_s    = flags_onehot({gt, eq, lt});
        idx_m1_s      = idx_r - IDX_W'(1);
        trial_upd_s   = trial;
        trial_probe_s = trial;
        if (gt) begin
            trial_upd_s[idx_r] = 1'b0;
        end else begin
            trial_upd_s[idx_r] = trial[idx_r];
        end
        trial_probe_s = trial_upd_s;
        if (idx_r != {IDX_W{1'b0}}) begin
            trial_probe_s[idx_m1_s] = 1'b1;
        end else begin
            trial_probe_s = trial_upd_s;
        end
    end

    // Search FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= IDX_W'(WIDTH - 1);
            trial   <= {WIDTH{1'b0}};
            result  <= {WIDTH{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            found   <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // First probe: MSB only.
                        trial   <= {1'b1, {(WIDTH-1){1'b0}}};
                        idx_r   <= IDX_W'(WIDTH - 1);
                        found   <= 1'b0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= TEST;
                    end else begin
                        trial   <= {WIDTH{1'b0}};
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                TEST: begin
                    if (!flags_ok_s) begin
                        // Invalid flag code: abort with the trial as it stood.
                        err     <= 1'b1;
                        found   <= 1'b0;
                        result  <= trial;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
`ifdef SAR_EARLY_EXIT_EN
                    end else if (eq) begin
                        found   <= 1'b1;
                        result  <= trial;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
`endif
                    end else begin
                        if (eq) begin
                            found <= 1'b1;
                        end else begin
                            found <= found;
                        end
                        if (idx_r != {IDX_W{1'b0}}) begin
                            trial   <= trial_probe_s;
                            idx_r   <= idx_m1_s;
                            state_r <= TEST;
                        end else begin
                            trial   <= trial_upd_s;
                            result  <= trial_upd_s;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    trial   <= {WIDTH{1'b0}};
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search_controller.sv
// ----------------------------------------------------------------------------
// tb_sar_search_controller
//
// Directed bench for sar_search_controller (WIDTH=8). A small behavioural
// comparator answers each probe from a bench-held target; an override can
// force an invalid flag code at a chosen probe. Expectations follow the
// SAR_EARLY_EXIT_EN build option.
// ----------------------------------------------------------------------------
module tb_sar_search_controller;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       gt;
    logic       eq;
    logic       lt;
    logic [7:0] trial;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       found;
    logic       err;

    logic [7:0] target;
    logic       bad;
    logic [7:0] probes [0:15];
    int         n_probes;

    int checks = 0;
    int errors = 0;

    sar_search_controller #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .gt     (gt),
        .eq     (eq),
        .lt     (lt),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural zero-latency comparator with invalid-code override.
    always_comb begin
        if (bad) begin
            {gt, eq, lt} = 3'b101;
        end else begin
            gt = (trial > target);
            eq = (trial == target);
            lt = (trial < target);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one search. start must already be 1 so the next edge is edge 0.
    task automatic do_search(input string tag, input logic [7:0] tgt,
                             input int bad_probe, input int extra_start_cyc,
                             input bit chain,
                             input logic [7:0] exp_res, input logic exp_found,
                             input logic exp_err, input int exp_done_cyc,
                             input int exp_busy_cyc);
        int  cyc;
        int  busy_cnt;
        bit  seen;
        target   = tgt;
        n_probes = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 1;
        check({tag, " first_trial"}, {24'd0, trial}, 32'h80);
        check({tag, " first_busy"}, {31'd0, busy}, 32'd1);
        check({tag, " err_cleared"}, {31'd0, err}, 32'd0);
        check({tag, " found_cleared"}, {31'd0, found}, 32'd0);
        while (cyc < 30) begin
            if (busy) begin
                busy_cnt++;
                if (n_probes < 16) probes[n_probes] = trial;
                n_probes++;
                bad = (n_probes == bad_probe);
            end else begin
                bad = 1'b0;
            end
            start = (cyc == extra_start_cyc);
            @(posedge clk); #1;
            bad   = 1'b0;
            start = 1'b0;
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        check({tag, " done_cycle"}, cyc, exp_done_cyc);
        check({tag, " busy_cycles"}, busy_cnt, exp_busy_cyc);
        check({tag, " busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, " result"}, {24'd0, result}, {24'd0, exp_res});
        check({tag, " found"}, {31'd0, found}, {31'd0, exp_found});
        check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
        if (chain) begin
            start = 1'b1;
        end else begin
            @(posedge clk); #1;
            check({tag, " done_pulse_1cyc"}, {31'd0, done}, 32'd0);
            check({tag, " trial_idle"}, {24'd0, trial}, 32'd0);
            check({tag, " result_held"}, {24'd0, result}, {24'd0, exp_res});
        end
    endtask

    initial begin
        logic [7:0] exp_a5 [0:7];
        int         early;
        exp_a5[0] = 8'h80; exp_a5[1] = 8'hC0; exp_a5[2] = 8'hA0; exp_a5[3] = 8'hB0;
        exp_a5[4] = 8'hA8; exp_a5[5] = 8'hA4; exp_a5[6] = 8'hA6; exp_a5[7] = 8'hA5;
`ifdef SAR_EARLY_EXIT_EN
        early = 1;
`else
        early = 0;
`endif
        rst_n  = 1'b0;
        start  = 1'b0;
        bad    = 1'b0;
        target = 8'h00;
        #12;
        check("reset trial", {24'd0, trial}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", {24'd0, result}, 32'd0);
        check("reset found", {31'd0, found}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Main search, target 0xA5, with a start pulse during TEST (ignored).
        start = 1'b1;
        do_search("a5", 8'hA5, 0, 3, 1'b0, 8'hA5, 1'b1, 1'b0, 9, 8);
        check("a5 n_probes", n_probes, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a5 probe%0d", i + 1), {24'd0, probes[i]}, {24'd0, exp_a5[i]});
        end

        // Target 0x00, chained back-to-back into target 0xFF.
        start = 1'b1;
        do_search("t00", 8'h00, 0, 0, 1'b1, 8'h00, 1'b0, 1'b0, 9, 8);
        do_search("tff", 8'hFF, 0, 0, 1'b0, 8'hFF, 1'b1, 1'b0, 9, 8);
        check("tff last_probe", {24'd0, probes[7]}, 32'hFF);

        // Target 0x80: eq on first probe.
        start = 1'b1;
        if (early != 0) begin
            do_search("t80", 8'h80, 0, 0, 1'b0, 8'h80, 1'b1, 1'b0, 2, 1);
        end else begin
            do_search("t80", 8'h80, 0, 0, 1'b0, 8'h80, 1'b1, 1'b0, 9, 8);
        end

        // Target 0x01: eq only at the last probe.
        start = 1'b1;
        do_search("t01", 8'h01, 0, 0, 1'b0, 8'h01, 1'b1, 1'b0, 9, 8);

        // Invalid flags at probe 3, chained into a clean search that clears err.
        start = 1'b1;
        do_search("errp3", 8'hA5, 3, 0, 1'b1, 8'hA0, 1'b0, 1'b1, 4, 3);
        do_search("after_err", 8'h3C, 0, 0, 1'b0, 8'h3C, 1'b1, 1'b0, 9, 8);

        // Asynchronous reset in the middle of a search (during probe 4).
        target = 8'hA5;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid probe4_trial", {24'd0, trial}, 32'hB0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async trial", {24'd0, trial}, 32'd0);
        check("async busy", {31'd0, busy}, 32'd0);
        check("async done", {31'd0, done}, 32'd0);
        check("async result", {24'd0, result}, 32'd0);
        check("async found", {31'd0, found}, 32'd0);
        check("async err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst idle", {31'd0, busy}, 32'd0);
        start = 1'b1;
        do_search("post_rst", 8'h5A, 0, 0, 1'b0, 8'h5A, 1'b1, 1'b0, 9, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
